// File: rtl/seg7_result_scanner.sv
// 8-digit multiplexed hex display of a 32-bit result word; optional leading-zero blanking under SEG_LZ_BLANK_EN.
// Latency: an/seg registered one cycle after scan index; accepted words appear at the next frame boundary.
// Backpressure: in_ready low while a word is pending; at most one word accepted per 8*SCAN_DIV-cycle frame.
module seg7_result_scanner #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_idx;
    logic [31:0]      r_disp;
    logic [31:0]      r_pend;
    logic             r_pend_full;
    logic [7:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_frame_done;

    logic             w_div_end;
    logic             w_frame_end;
    logic             w_xfer;
    logic             w_commit;
    logic [3:0]       w_nib;
    logic             w_blank;
    logic [7:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_div_end   = (r_div == DIV_LAST);
    assign w_frame_end = w_div_end && (r_idx == 3'd7);
    assign w_xfer      = in_valid && !r_pend_full;
    // A commit needs pending full and a transfer needs it empty, so the two never collide.
    assign w_commit    = w_frame_end && r_pend_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= 3'd0;
        end else if (w_div_end) begin
            r_div <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp      <= 32'h0;
            r_pend      <= 32'h0;
            r_pend_full <= 1'b0;
        end else if (w_commit) begin
            r_disp      <= r_pend;
            r_pend_full <= 1'b0;
        end else if (w_xfer) begin
            r_pend      <= data_in;
            r_pend_full <= 1'b1;
        end
    end

    assign w_nib = r_disp[{r_idx, 2'b00} +: 4];

`ifdef SEG_LZ_BLANK_EN
    logic [7:0] w_lz;

    // Digit i is a leading zero when every nibble from i upward is zero; digit 0 always shows.
    assign w_lz[0] = 1'b0;
    for (genvar gi = 1; gi < 8; gi++) begin : g_lz
        assign w_lz[gi] = ~|r_disp[31:4*gi];
    end
    assign w_blank = w_lz[r_idx];
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_an_nxt  = ~(8'b1 << r_idx);
        w_seg_nxt = seg_decode(w_nib);
        if (w_blank) begin
            w_an_nxt  = 8'hFF;
            w_seg_nxt = 7'h7F;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an         <= 8'hFF;
            r_seg        <= 7'h7F;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
            r_frame_done <= w_frame_end;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = 1'b1;
    assign frame_done = r_frame_done;
    assign in_ready   = !r_pend_full;

endmodule

// File: tb/tb_seg7_result_scanner.sv
// Scoreboard bench for seg7_result_scanner at SCAN_DIV=4: transaction model predicts the word shown in each frame.
module tb_seg7_result_scanner;

    localparam int D  = 4;
    localparam int FR = 8 * D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // Model state: edges since reset release, pending/display words, per-frame expected words.
    int          k = 0;
    logic        mfull = 1'b0;
    logic [31:0] mpend = 32'h0;
    logic [31:0] mdisp = 32'h0;
    logic [31:0] exp_q[$];

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_result_scanner #(.SCAN_DIV(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin : model
        logic old_full;
        logic boundary;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                k = 0;
                mfull = 1'b0;
                mpend = 32'h0;
                mdisp = 32'h0;
                exp_q.delete();
                exp_q.push_back(32'h0);
            end else begin
                k++;
                old_full = mfull;
                boundary = (k % FR == 0);
                if (boundary && old_full) begin
                    mdisp = mpend;
                    mfull = 1'b0;
                end
                if (in_valid && !old_full) begin
                    mpend = data_in;
                    mfull = 1'b1;
                end
                if (boundary) exp_q.push_back(mdisp);
            end
        end
    end

    initial begin : monitor
        logic [31:0] cur;
        int          d;
        logic [7:0]  ea;
        logic [6:0]  es;
        logic        efd;
        cur = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n || k == 0) begin
                checks++;
                if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_outputs t=%0t: an=%h seg=%h dp=%b rdy=%b fd=%b, required an=ff seg=7f dp=1 rdy=1 fd=0",
                             $time, an, seg, dp, in_ready, frame_done);
                end
            end else begin
                if (k % FR == 1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_queue k=%0d: no expected frame word available", k);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                d  = ((k - 1) / D) % 8;
                ea = ~(8'b1 << d);
                es = seg_tbl[(cur >> (4 * d)) & 32'hF];
`ifdef SEG_LZ_BLANK_EN
                if (d >= 1 && (cur >> (4 * d)) == 32'h0) begin
                    ea = 8'hFF;
                    es = 7'h7F;
                end
`endif
                checks++;
                if (an !== ea || seg !== es || dp !== 1'b1) begin
                    errors++;
                    $display("FAIL slot k=%0d digit=%0d word=%h: an=%h seg=%h dp=%b, required an=%h seg=%h dp=1",
                             k, d, cur, an, seg, dp, ea, es);
                end
                efd = (k % FR == 0);
                checks++;
                if (frame_done !== efd) begin
                    errors++;
                    $display("FAIL frame_done k=%0d: got %b, required %b", k, frame_done, efd);
                end
                checks++;
                if (in_ready !== !mfull) begin
                    errors++;
                    $display("FAIL in_ready k=%0d: got %b, required %b", k, in_ready, !mfull);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the word with in_valid until a handshake edge occurs.
    task automatic send(input logic [31:0] w);
        int   n;
        logic rdy;
        n = 0;
        data_in  = w;
        in_valid = 1'b1;
        forever begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 4 * FR) begin
                checks++;
                errors++;
                $display("FAIL send_timeout word=%h: in_ready stayed %b, required 1 within %0d cycles", w, in_ready, 4 * FR);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] w);
        data_in  = w;
        in_valid = 1'b1;
        wait_cycles(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_phase(input int ph, input logic need_empty);
        int n;
        n = 0;
        while (!((k % FR) == ph && (!need_empty || !mfull))) begin
            wait_cycles(1);
            n++;
            if (n > 4 * FR) begin
                checks++;
                errors++;
                $display("FAIL phase_timeout: phase %0d not reached, k=%0d full=%b", ph, k, mfull);
                break;
            end
        end
    endtask

    initial begin : driver
        logic [31:0] w;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2 * FR + 8);

        send(32'h1234_ABCD);
        pulse(32'hFFFF_FFFF);
        send(32'hFFFF_FFFF);
        wait_cycles(2 * FR + 4);

        wait_phase(FR - 1, 1'b1);
        pulse(32'h0000_0005);
        wait_cycles(2 * FR + 4);

        wait_phase(1, 1'b1);
        send(32'hDEAD_BEEF);
        wait_phase(14, 1'b0);
        #1;
        rst_n = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2 * FR + 4);

        send(32'h0000_00A5);
        wait_cycles(2 * FR);
        send(32'h0000_0000);
        wait_cycles(2 * FR);

        for (int i = 0; i < 25; i++) begin
            wait_cycles($urandom_range(0, 50));
            w = $urandom;
            if ($urandom_range(0, 2) == 0) w = w >> (4 * $urandom_range(1, 7));
            if ($urandom_range(0, 3) == 0) pulse(w);
            else send(w);
        end
        wait_cycles(3 * FR);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
